// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared stage types, widths and stage-state encoding
// Control fields sit in the struct LSBs so the stage can zero them without knowing the layout.
package pipe_stage_skid_pkg;

    // Encoding is {skid_valid, main_valid}; 2'b10 has no name because it must never occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       halt;
        logic       dwen;
        logic       dren;
        logic       regwr;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [15:0] imm;
        logic [7:0]  alu_op;
        ctrl_t       ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_val;
        logic [4:0]  wsel;
        logic [2:0]  pad;
        ctrl_t       ctrl;
    } ex_mem_t;

    localparam int CTRL_BITS      = $bits(ctrl_t);
    localparam int ID_EX_W        = $bits(id_ex_t);
    localparam int EX_MEM_W       = $bits(ex_mem_t);
    localparam int DEFAULT_DATA_W = ID_EX_W;
    localparam int DEFAULT_CTRL_W = CTRL_BITS;
    localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload stream between pipeline stages
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload register with load, control-bit clear and async reset
module pipe_entry_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_squashed;

    always_comb begin
        q_squashed = q;
        for (int i = 0; i < CTRL_W; i++) begin
            q_squashed[i] = 1'b0;
        end
    end

    // Clear wins over load so a flushed payload never re-enters with live control bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else if (clr) begin
            q <= q_squashed;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid pipeline stage with flush and stall counter
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    input  logic                 flush,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    if (CTRL_W < 1 || DATA_W < CTRL_W) begin : g_bad_width
        $error("pipe_stage_skid: need DATA_W >= CTRL_W >= 1");
    end

    stage_state_e      state;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              emit;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic              entry_clr;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_d;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // in_ready comes straight from a flop, so upstream never sees a combinational path from dn.
    assign up.tready = ~skid_valid;
    assign dn.tvalid = main_valid;
    assign dn.tdata  = main_q;

    assign accept = up.tvalid & ~skid_valid;
    assign emit   = main_valid & dn.tready;

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: main_load = accept;
            BUSY: begin
                if (accept && emit) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                end
            end
            FULL: begin
                main_load      = emit;
                main_from_skid = emit;
            end
            default: ;
        endcase
        entry_clr = flush && (state != EMPTY);
    end

    assign main_d = main_from_skid ? skid_q : up.tdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state <= BUSY;
                BUSY: begin
                    if (accept && !emit) begin
                        state <= FULL;
                    end else if (!accept && emit) begin
                        state <= EMPTY;
                    end
                end
                FULL: if (emit) state <= BUSY;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (main_valid && !dn.tready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .CLK  (CLK),
        .RST  (RST),
        .load (main_load),
        .clr  (entry_clr),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .CLK  (CLK),
        .RST  (RST),
        .load (skid_load),
        .clr  (entry_clr),
        .d    (up.tdata),
        .q    (skid_q)
    );

    a_no_skid_only: assert property (@(posedge CLK) disable iff (RST) !(skid_valid && !main_valid));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [NW-1:0] stall_cnt;

    pipe_stage_skid_if #(.DATA_W(DW)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DW)) dn_if ();

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    int            occ = 0;
    int            stall_m = 0;
    int            n_emitted = 0;

    // One clock of stimulus: compare registered outputs against the model, then advance both.
    task automatic step(input logic vin, input logic [DW-1:0] din, input logic rdy,
                        input logic fl, input logic clr);
        bit acc, em;
        up_if.tvalid = vin;
        up_if.tdata  = din;
        dn_if.tready = rdy;
        flush        = fl;
        clr_cnt      = clr;
        n_checks++;
        if (up_if.tready !== (occ < 2)) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b (occ %0d)", up_if.tready, occ < 2, occ);
        end
        n_checks++;
        if (dn_if.tvalid !== (occ > 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", dn_if.tvalid, occ > 0);
        end
        n_checks++;
        if (stall_cnt !== NW'(stall_m)) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall_m);
        end
        if (occ > 0) begin
            n_checks++;
            if (dn_if.tdata !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_data: got %h expected %h", dn_if.tdata, exp_q[0]);
            end
        end
        acc = vin && (occ < 2);
        em  = (occ > 0) && rdy;
        if (clr) stall_m = 0;
        else if (occ > 0 && !rdy && !fl && stall_m < SMAX) stall_m++;
        if (fl) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (em) begin
                void'(exp_q.pop_front());
                occ--;
                n_emitted++;
            end
            if (acc) begin
                exp_q.push_back(din);
                occ++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ = 0;
        stall_m = 0;
    endtask

    task automatic test_reset();
        up_if.tvalid = 1'b0;
        up_if.tdata  = '0;
        dn_if.tready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dn_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", dn_if.tvalid); end
        n_checks++;
        if (up_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", up_if.tready); end
        n_checks++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_checks++;
        if (dn_if.tdata !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", dn_if.tdata); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        int base;
        base = n_emitted;
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (n_emitted - base != 4) begin n_fail++; $display("FAIL stream_count: got %0d expected 4", n_emitted - base); end
    endtask

    task automatic test_backpressure();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        int base;
        step(1'b1, 32'h1234_56AB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h5555_55CD, 1'b0, 1'b0, 1'b0);
        base = n_emitted;
        step(1'b1, 32'h0000_00C3, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dn_if.tdata[CW-1:0] !== '0) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 00", dn_if.tdata[CW-1:0]); end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (n_emitted != base) begin n_fail++; $display("FAIL flush_no_emit: got %0d expected %0d", n_emitted, base); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
        up_if.tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dn_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid: got %b expected 0", dn_if.tvalid); end
        n_checks++;
        if (up_if.tready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready: got %b expected 1", up_if.tready); end
        n_checks++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL async_stall_cnt: got %0d expected 0", stall_cnt); end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_value: got %0d expected 15", stall_cnt); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", stall_cnt); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int sent, cyc, base;
        logic vin, rdy;
        logic [DW-1:0] d;
        sent = 0;
        cyc  = 0;
        base = n_emitted;
        while ((sent < 1000 || occ > 0) && cyc < 20000) begin
            vin = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d   = DW'($urandom);
            if (vin && occ < 2) sent++;
            step(vin, d, rdy, 1'b0, 1'b0);
            cyc++;
        end
        n_checks++;
        if (cyc >= 20000) begin n_fail++; $display("FAIL random_timeout: got %0d cycles expected < 20000", cyc); end
        n_checks++;
        if (n_emitted - base != 1000) begin n_fail++; $display("FAIL random_count: got %0d expected 1000", n_emitted - base); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
